// File: rtl/axis_head_cut_ctrl.sv
// Per-packet head cutter for AXI-stream: each command discards that many leading
// beats of the next packet and forwards the rest through one output register.
module axis_head_cut_ctrl #(
    parameter int DSIZE = 8,
    parameter int LSIZE = 16
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [LSIZE-1:0] cmd_len,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [DSIZE-1:0] slaver_tdata,
    input  logic             slaver_tvalid,
    input  logic             slaver_tlast,
    output logic             slaver_tready,
    output logic [DSIZE-1:0] master_tdata,
    output logic             master_tvalid,
    output logic             master_tlast,
    input  logic             master_tready,
    output logic             busy,
    output logic [15:0]      drop_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CUT  = 2'd1,
        PASS = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [LSIZE-1:0] len_q, len_d;
    logic [LSIZE-1:0] cnt_q, cnt_d;
    logic             drop_inc;
    logic             load_beat;
    logic             out_free;

    logic [DSIZE-1:0] out_data_q;
    logic             out_valid_q;
    logic             out_last_q;
    logic [15:0]      drop_cnt_q;

    assign out_free = !out_valid_q || master_tready;

    // State register
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        drop_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    len_d   = cmd_len;
                    cnt_d   = '0;
                    state_d = (cmd_len == '0) ? PASS : CUT;
                end
            end
            CUT: begin
                if (slaver_tvalid) begin
                    cnt_d = cnt_q + LSIZE'(1);
                    // A packet that ends inside the cut is dropped whole, even on the final cut beat.
                    if (slaver_tlast) begin
                        state_d  = IDLE;
                        drop_inc = 1'b1;
                    end else if (cnt_q == len_q - LSIZE'(1)) begin
                        state_d = PASS;
                    end
                end
            end
            PASS: begin
                if (slaver_tvalid && out_free && slaver_tlast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        cmd_ready     = 1'b0;
        slaver_tready = 1'b0;
        load_beat     = 1'b0;
        case (state_q)
            IDLE: cmd_ready = 1'b1;
            CUT:  slaver_tready = 1'b1;
            PASS: begin
                slaver_tready = out_free;
                load_beat     = slaver_tvalid && out_free;
            end
            default: ;
        endcase
    end

    // Single skid-free output stage; holds its beat until the downstream takes it.
    always_ff @(posedge clock) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (load_beat) begin
            out_data_q  <= slaver_tdata;
            out_valid_q <= 1'b1;
            out_last_q  <= slaver_tlast;
        end else if (master_tready) begin
            out_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else if (drop_inc && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign master_tdata  = out_data_q;
    assign master_tvalid = out_valid_q;
    assign master_tlast  = out_last_q;
    assign drop_cnt      = drop_cnt_q;
    assign busy          = (state_q != IDLE) || out_valid_q;

endmodule

// File: doc/axis_head_cut_ctrl.md
Name: axis_head_cut_ctrl

Overview:
- Per-packet head-cut sequencer for AXI-stream.
- A command channel supplies one cut length per packet. The block discards that many leading beats of the next slaver packet and forwards the remainder to master.
- Packets that are consumed entirely by the cut are dropped whole and counted.
- Sits in front of packet parsers wherever the header length varies per packet, so a fixed-length cutter cannot be used.

Parameters:
- DSIZE, 8, tdata width in bits.
- LSIZE, 16, width of the cut-length command and of the internal beat counter.

Ports:
- clock, input, 1, single clock; all logic on the rising edge.
- rst, input, 1, synchronous active-high reset.
- cmd_len, input, LSIZE, number of head beats to cut from the next packet.
- cmd_valid, input, 1, command valid.
- cmd_ready, output, 1, command accepted when cmd_valid && cmd_ready.
- slaver_tdata, input, DSIZE, upstream data.
- slaver_tvalid, input, 1, upstream valid.
- slaver_tlast, input, 1, upstream end of packet.
- slaver_tready, output, 1, upstream ready.
- master_tdata, output, DSIZE, downstream data (registered).
- master_tvalid, output, 1, downstream valid (registered).
- master_tlast, output, 1, downstream end of packet (registered).
- master_tready, input, 1, downstream ready.
- busy, output, 1, high when the FSM is not in IDLE or the output register holds a beat.
- drop_cnt, output, 16, count of packets dropped whole; saturates at 16'hFFFF.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, beat counter=0, length register=0.
  - master_tvalid=0, master_tdata=0, master_tlast=0.
  - drop_cnt=0.
  - Combinational outputs follow from state: cmd_ready=1, slaver_tready=0, busy=0.
- Beat handshakes are AXI-stream: a beat transfers when valid && ready at a clock edge. Once master_tvalid is asserted, master_tdata and master_tlast stay stable until master_tready.
- Output register:
  - One stage.
  - Can accept a new beat when out_free = !master_tvalid || master_tready.
  - Forwarding latency is one cycle: a slaver beat accepted at edge N is on master from edge N.
- FSM states:
  - IDLE:
    - cmd_ready=1, slaver_tready=0.
    - On a cmd handshake: latch cmd_len and clear the counter.
    - Go to PASS if cmd_len==0, else to CUT.
  - CUT:
    - cmd_ready=0, slaver_tready=1 (beats are discarded and never reach master).
    - Each accepted beat increments the counter.
    - Accepted beat with tlast=1 (this includes the case where it is also beat index len-1): drop_cnt increments, go to IDLE. The packet produces no master output.
    - Accepted beat with tlast=0 and counter==len-1: go to PASS.
  - PASS:
    - cmd_ready=0, slaver_tready=out_free.
    - Each accepted beat is loaded into the output register with its tlast.
    - Accepted beat with tlast=1: go to IDLE.
- Throughput: one idle cycle per packet, for command acceptance in IDLE. Within a packet, full rate is sustained when master_tready is held at 1.
- master_tready low in PASS: slaver_tready drops in the same cycle, and no beat is lost or duplicated.
- master_tready is ignored in CUT; the cut proceeds at slaver rate.
- cmd_valid with no slaver traffic: the command is held and the FSM waits in CUT/PASS indefinitely.
- Slaver beats arriving in IDLE are stalled (tready=0) and never discarded.
- Counter arithmetic:
  - Unsigned, LSIZE bits.
  - cmd_len = 2^LSIZE-1 is legal.
  - The counter never wraps, because the state exits at len-1.
- drop_cnt holds at 16'hFFFF once reached.
- busy = (state != IDLE) || master_tvalid.
- rst mid-packet:
  - State and output register are cleared immediately; any pending master beat is discarded.
  - Remaining upstream beats of the interrupted packet are stalled until the next command, which is then applied to that remainder. Recovering upstream alignment is the system's responsibility.

Test Plan:
- cmd_len=2, 6-beat packet D0..D5, master_tready=1 -> master carries D2..D5, tlast on D5, first master beat one cycle after D2 is accepted; drop_cnt=0.
- cmd_len=0, 3-beat packet A,B,C -> master carries A,B,C unchanged; after the tlast handshake, cmd_ready=1 on the following cycle.
- cmd_len=4, 3-beat packet and separately cmd_len=3, 3-beat packet -> no master beats in either case; drop_cnt=2; FSM back in IDLE after each tlast.
- cmd_len=1, 8-beat packet, master_tready toggling 1,0,0,1 repeating -> exactly beats 1..7 are delivered in order with no duplicates; master_tdata is stable while stalled.
- Back-to-back commands (len 1, then len 2) with packets of 4 and 5 beats -> outputs are beats 1..3 of packet 0 and beats 2..4 of packet 1; exactly one idle cycle between the packets.
- Assert rst during PASS with master_tvalid=1 -> next cycle master_tvalid=0, drop_cnt=0, cmd_ready=1, slaver_tready=0. Then issue cmd_len=0 -> the stalled remainder is forwarded.
